lut_mult2x2_fabric: RTL and testbench
=====================================

// Module: lut_mult2x2_fabric
// PURPOSE
// - Reprogrammable LUT fabric slice that computes z = a * b for 2-bit unsigned operands.
// - Four 4-input LUTs (one per product bit) are addressed by {a,b}.
// - LUT contents reset to the multiplier truth table and can be reloaded through a serial configuration chain.
// - Used as the programmable-logic core behind the top-level pad/bitstream wrapper.
// PARAMETERS
// - OUT_REG  default 0  0: z is combinational from a/b; 1: z is registered (1-cycle latency)
// PORTS
// - clk           input   1   single system clock, rising edge
// - global_reset  input   1   asynchronous, active-high; clears all state to defaults
// - a             input   2   operand A, unsigned (LUT address bits [3:2])
// - b             input   2   operand B, unsigned (LUT address bits [1:0])
// - z             output  4   product a*b; z[i] = LUT i output
// - cfg_en        input   1   shift enable for the serial configuration chain
// - cfg_din       input   1   serial configuration data in
// - cfg_load      input   1   one-cycle pulse: copy shadow chain into active LUTs
// - cfg_dout      output  1   serial out = shadow[63] (for chaining/readback)
// BEHAVIOUR
// - Storage: 64-bit shadow chain sh[63:0] and 64-bit active array lut[63:0].
//   - LUT i = lut[16*i+15 : 16*i]
//   - z[i] = LUT_i[{a,b}], i.e. index k = 4*a + b
// - Default table (both sh and lut after reset), with LUT3 in the MSBs:
//   - {LUT3,LUT2,LUT1,LUT0} = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0}
//   - Bit k of LUT i = bit i of (k[3:2] * k[1:0]), i.e. an exact 2x2 unsigned multiply; max result 9 (4'b1001).
// - Reset (global_reset=1, async assert; deassert is synchronous to clk):
//   - sh and lut take the default table.
//   - cfg_dout = 1.
//   - If OUT_REG=1, z = 4'h0.
//   - If OUT_REG=0, z is immediately the correct product for the current a/b.
// - Shift: on a rising clk edge with cfg_en=1 and cfg_load=0, sh <= {sh[62:0], cfg_din}.
//   - The first bit shifted in ends up at sh[63] (LUT3 bit 15) after 64 shifts.
// - Load: on a rising clk edge with cfg_load=1, lut <= sh.
//   - cfg_load has priority: no shift occurs that cycle even if cfg_en=1.
// - Active LUTs never change during shifting; z keeps computing from the old table until a load.
// - Timing of z:
//   - OUT_REG=0: z is purely combinational from a, b and lut; settles within the same cycle, no clock needed.
//   - OUT_REG=1: z registered on the rising edge; reflects a/b/lut sampled at that edge.
// - Boundaries:
//   - More than 64 shifts: the oldest bits fall out via cfg_dout.
//   - Fewer than 64 shifts before load: a partially shifted mix of old and new bits is loaded as-is.
//   - Reset mid-shift or coincident with load: reset wins; defaults restored.
//   - Back-to-back loads: each load copies the current sh.
// - No X propagation: all registers are reset; the a/b index is always in range 0..15.
// TESTING
// - After reset, sweep all 16 {a,b} pairs, OUT_REG=0 -> z = a*b each (e.g. 1*3=3, 2*2=4, 2*3=6, 3*3=9, x*0=0).
// - OUT_REG=1: a=3, b=3 -> z=9 one rising edge later; z=0 while in reset.
// - Shift 64 bits of all-ones, no load -> z unchanged (a=2, b=2 -> 4); then pulse cfg_load -> z=4'hF for every a/b.
// - cfg_en=1 together with cfg_load=1 -> lut gets the pre-shift sh; sh itself is not shifted that cycle.
// - Shift 64 bits of the table for z = a+b, then load -> a=3, b=3 gives z=6; then assert global_reset -> z=9 again.
// - cfg_dout readback: after reset, shift 64 zeros and capture cfg_dout -> bit stream equals the default table, MSB (sh[63]) first.

Source files
------------

// File: rtl/lut_mult2x2_fabric.sv
// rtl/lut_mult2x2_fabric.sv - reprogrammable 4-LUT slice computing a 2x2 unsigned product
module lut_mult2x2_fabric #(
    parameter int OUT_REG = 0
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] z,
    input  logic       cfg_en,
    input  logic       cfg_din,
    input  logic       cfg_load,
    output logic       cfg_dout
);

    // {LUT3, LUT2, LUT1, LUT0}: bit k of LUT i is bit i of k[3:2]*k[1:0]
    localparam logic [63:0] DEFAULT_TABLE = {16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0};

    logic [63:0] sh;
    logic [63:0] lut;
    logic [3:0]  idx;
    logic [3:0]  z_comb;

    assign idx      = {a, b};
    assign cfg_dout = sh[63];

    // Shadow chain: shifts toward the MSB; a load in the same cycle freezes it
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            sh <= DEFAULT_TABLE;
        end else if (cfg_en && !cfg_load) begin
            sh <= {sh[62:0], cfg_din};
        end
    end

    // Active table: only changes on a load, so shifting never disturbs z
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            lut <= DEFAULT_TABLE;
        end else if (cfg_load) begin
            lut <= sh;
        end
    end

    // One 16:1 LUT read per product bit, all addressed by {a,b}
    for (genvar i = 0; i < 4; i++) begin : g_lut
        logic [15:0] lut_word;
        assign lut_word  = lut[16*i +: 16];
        assign z_comb[i] = lut_word[idx];
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [3:0] z_q;

        // Registered product: samples a/b and the active table at the edge
        always_ff @(posedge clk or posedge global_reset) begin
            if (global_reset) begin
                z_q <= 4'h0;
            end else begin
                z_q <= z_comb;
            end
        end

        assign z = z_q;
    end else begin : g_out_comb
        assign z = z_comb;
    end

endmodule

// File: tb/tb_lut_mult2x2_fabric.sv
// tb/tb_lut_mult2x2_fabric.sv - scoreboard bench for lut_mult2x2_fabric, both output modes
module tb_lut_mult2x2_fabric;

    logic       clk = 1'b0;
    logic       global_reset = 1'b1;
    logic [1:0] a = 2'd0;
    logic [1:0] b = 2'd0;
    logic       cfg_en = 1'b0;
    logic       cfg_din = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] z_c;
    logic [3:0] z_r;
    logic       dout_c;
    logic       dout_r;

    always #5 clk = ~clk;

    lut_mult2x2_fabric #(.OUT_REG(0)) u_dut_comb (
        .clk(clk), .global_reset(global_reset), .a(a), .b(b), .z(z_c),
        .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_load(cfg_load), .cfg_dout(dout_c)
    );

    lut_mult2x2_fabric #(.OUT_REG(1)) u_dut_reg (
        .clk(clk), .global_reset(global_reset), .a(a), .b(b), .z(z_r),
        .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_load(cfg_load), .cfg_dout(dout_r)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        logic [3:0] z;
        logic       dout;
    } exp_t;

    exp_t q_comb[$];
    exp_t q_reg[$];

    // Reference model: active function as a 16-entry table of products,
    // shadow chain as an ordered bit vector (sh[63] = oldest bit)
    logic [3:0]  m_tab [16];
    logic [63:0] m_sh;
    bit          prev_rst = 1'b1;

    function automatic logic [63:0] table_bits(input logic [3:0] t [16]);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 4; i++)
                r[16*i+k] = t[k][i];
        return r;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 16; k++) m_tab[k] = 4'((k / 4) * (k % 4));
        m_sh = table_bits(m_tab);
    endfunction

    function automatic void m_load();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 4; i++)
                m_tab[k][i] = m_sh[16*i+k];
    endfunction

    function automatic logic [63:0] sum_table();
        logic [3:0] t [16];
        for (int k = 0; k < 16; k++) t[k] = 4'((k / 4) + (k % 4));
        return table_bits(t);
    endfunction

    // One clock of stimulus; expectations go to the queues, the model then advances past the edge
    task automatic step(input logic [1:0] ta, input logic [1:0] tb, input logic en,
                        input logic din, input logic ld, input logic rst);
        @(posedge clk);
        #1;
        a = ta; b = tb; cfg_en = en; cfg_din = din; cfg_load = ld; global_reset = rst;
        if (rst) begin
            m_reset();
            q_reg.delete();
            q_reg.push_back('{cyc, 4'h0, 1'b0});
        end else if (prev_rst) begin
            q_reg.push_back('{cyc, 4'h0, 1'b0});
        end
        q_comb.push_back('{cyc, m_tab[{ta, tb}], m_sh[63]});
        if (!rst) begin
            q_reg.push_back('{cyc + 1, m_tab[{ta, tb}], 1'b0});
            if (ld) m_load();
            else if (en) m_sh = {m_sh[62:0], din};
        end
        prev_rst = rst;
    endtask

    task automatic sweep();
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            step(kk[3:2], kk[1:0], 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic shift_word(input logic [63:0] w, input int n);
        for (int j = 0; j < n; j++)
            step(2'($urandom), 2'($urandom), 1'b1, w[63-j], 1'b0, 1'b0);
    endtask

    // Monitor: compare whatever expectations are due this cycle
    always @(negedge clk) begin
        while (q_comb.size() > 0 && q_comb[0].due <= cyc) begin
            exp_t e;
            e = q_comb.pop_front();
            checks += 3;
            if (e.due != cyc || z_c !== e.z) begin
                errors++;
                $display("FAIL z_comb cyc=%0d a=%0d b=%0d got %h expected %h", cyc, a, b, z_c, e.z);
            end
            if (e.due != cyc || dout_c !== e.dout) begin
                errors++;
                $display("FAIL cfg_dout_comb cyc=%0d got %b expected %b", cyc, dout_c, e.dout);
            end
            if (e.due != cyc || dout_r !== e.dout) begin
                errors++;
                $display("FAIL cfg_dout_reg cyc=%0d got %b expected %b", cyc, dout_r, e.dout);
            end
        end
        while (q_reg.size() > 0 && q_reg[0].due <= cyc) begin
            exp_t e;
            e = q_reg.pop_front();
            checks++;
            if (e.due != cyc || z_r !== e.z) begin
                errors++;
                $display("FAIL z_reg cyc=%0d got %h expected %h", cyc, z_r, e.z);
            end
        end
    end

    initial begin
        m_reset();

        // Reset held over a few cycles, then the full product sweep
        step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        sweep();

        // Readback: zeros push the default table out MSB first
        shift_word(64'h0, 64);

        // All ones shifted without a load leave the product intact, then load
        shift_word({64{1'b1}}, 64);
        step(2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        sweep();

        // Load wins over shift in the same cycle, then back-to-back loads
        shift_word({$urandom, $urandom}, 64);
        step(2'd1, 2'd1, 1'b1, 1'($urandom), 1'b1, 1'b0);
        sweep();
        shift_word({$urandom, $urandom}, 10);
        step(2'd3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'd3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        sweep();

        // Partial shift then load mixes old and new bits
        step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        shift_word({$urandom, $urandom}, 20);
        step(2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        sweep();

        // Reprogram as an adder, then reset restores the multiplier
        shift_word(sum_table(), 64);
        step(2'd3, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        sweep();
        shift_word({$urandom, $urandom}, 7);
        step(2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        step(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        sweep();

        // Random traffic with occasional loads and resets
        for (int n = 0; n < 400; n++)
            step(2'($urandom), 2'($urandom), 1'($urandom_range(3, 0) != 0), 1'($urandom),
                 1'($urandom_range(15, 0) == 0), 1'($urandom_range(99, 0) == 0));

        for (int n = 0; n < 3; n++) step(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q_comb.size() != 0 || q_reg.size() != 0) begin
            errors++;
            $display("FAIL drain pending comb=%0d reg=%0d expected 0", q_comb.size(), q_reg.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
